// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute control unit for the 8-bit
// accumulator micro-computer. Owns the T-state counter and the run/halt
// state, and decodes (state, sc, ir, flags) into per-cycle datapath strobes.
// Strobes are combinational and are forced low whenever rst_n is low, so an
// asynchronous reset aborts an instruction without leaving a strobe active.

module control_sequencer #(
  parameter bit AUTO_START = 1'b1,
  parameter int SC_W       = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      ir,
  input  logic            ac_zero,
  input  logic            dr_zero,
  input  logic            e_in,
  output logic [SC_W-1:0] sc,
  output logic            halted,
  output logic            ar_ld,
  output logic            ar_sel,
  output logic            ar_inc,
  output logic            pc_ld,
  output logic            pc_inc,
  output logic            ir_ld,
  output logic            dr_ld,
  output logic            dr_inc,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [1:0]      wr_sel,
  output logic            ac_ld,
  output logic            e_ld,
  output logic [3:0]      alu_op
);

  typedef enum logic [0:0] {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = AUTO_START ? ST_RUN : ST_HALT;

  // T-state numbers
  localparam logic [SC_W-1:0] T0 = SC_W'(0);
  localparam logic [SC_W-1:0] T1 = SC_W'(1);
  localparam logic [SC_W-1:0] T2 = SC_W'(2);
  localparam logic [SC_W-1:0] T3 = SC_W'(3);
  localparam logic [SC_W-1:0] T4 = SC_W'(4);
  localparam logic [SC_W-1:0] T5 = SC_W'(5);

  // Memory-reference opcodes and the register-op group
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_BUN = 4'h4;
  localparam logic [3:0] OP_BSA = 4'h5;
  localparam logic [3:0] OP_ISZ = 4'h6;
  localparam logic [3:0] OP_REG = 4'h7;

  // Register-op codes in ir[3:0]
  localparam logic [3:0] RO_CLA = 4'h0;
  localparam logic [3:0] RO_CMA = 4'h1;
  localparam logic [3:0] RO_CME = 4'h2;
  localparam logic [3:0] RO_CIR = 4'h3;
  localparam logic [3:0] RO_CIL = 4'h4;
  localparam logic [3:0] RO_INC = 4'h5;
  localparam logic [3:0] RO_SZA = 4'h6;
  localparam logic [3:0] RO_SEZ = 4'h7;
  localparam logic [3:0] RO_HLT = 4'hF;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_PASS = 4'd2;
  localparam logic [3:0] ALU_CLR  = 4'd3;
  localparam logic [3:0] ALU_CMA  = 4'd4;
  localparam logic [3:0] ALU_CIR  = 4'd5;
  localparam logic [3:0] ALU_CIL  = 4'd6;
  localparam logic [3:0] ALU_INC  = 4'd7;
  localparam logic [3:0] ALU_CME  = 4'd8;

  // Memory write data sources
  localparam logic [1:0] WS_AC = 2'd0;
  localparam logic [1:0] WS_PC = 2'd1;
  localparam logic [1:0] WS_DR = 2'd2;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [SC_W-1:0] sc_r;
  logic [SC_W-1:0] sc_nxt_s;

  logic [3:0] op_s;
  logic [3:0] rop_s;
  logic       clr_s;
  logic       hlt_s;

  logic       ar_ld_s;
  logic       ar_sel_s;
  logic       ar_inc_s;
  logic       pc_ld_s;
  logic       pc_inc_s;
  logic       ir_ld_s;
  logic       dr_ld_s;
  logic       dr_inc_s;
  logic       mem_rd_s;
  logic       mem_wr_s;
  logic [1:0] wr_sel_s;
  logic       ac_ld_s;
  logic       e_ld_s;
  logic [3:0] alu_op_s;

  assign op_s  = ir[7:4];
  assign rop_s = ir[3:0];

  // Run/halt state and sequence counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE;
      sc_r    <= T0;
    end else begin
      state_r <= state_nxt_s;
      sc_r    <= sc_nxt_s;
    end
  end

  // Strobe decode and next-state / next-T-state selection
  always_comb begin
    ar_ld_s     = 1'b0;
    ar_sel_s    = 1'b0;
    ar_inc_s    = 1'b0;
    pc_ld_s     = 1'b0;
    pc_inc_s    = 1'b0;
    ir_ld_s     = 1'b0;
    dr_ld_s     = 1'b0;
    dr_inc_s    = 1'b0;
    mem_rd_s    = 1'b0;
    mem_wr_s    = 1'b0;
    wr_sel_s    = WS_AC;
    ac_ld_s     = 1'b0;
    e_ld_s      = 1'b0;
    alu_op_s    = ALU_AND;
    clr_s       = 1'b0;
    hlt_s       = 1'b0;
    state_nxt_s = state_r;
    sc_nxt_s    = T0;

    if (state_r == ST_RUN) begin
      case (sc_r)
        T0: begin
          ar_ld_s = 1'b1;
        end
        T1: begin
          mem_rd_s = 1'b1;
          ir_ld_s  = 1'b1;
          pc_inc_s = 1'b1;
        end
        T2: begin
          if (op_s <= OP_ISZ) begin
            ar_ld_s  = 1'b1;
            ar_sel_s = 1'b1;
          end else if (op_s == OP_REG) begin
            clr_s = 1'b1;
            case (rop_s)
              RO_CLA: begin ac_ld_s = 1'b1; alu_op_s = ALU_CLR; end
              RO_CMA: begin ac_ld_s = 1'b1; alu_op_s = ALU_CMA; end
              RO_CME: begin e_ld_s  = 1'b1; alu_op_s = ALU_CME; end
              RO_CIR: begin ac_ld_s = 1'b1; e_ld_s = 1'b1; alu_op_s = ALU_CIR; end
              RO_CIL: begin ac_ld_s = 1'b1; e_ld_s = 1'b1; alu_op_s = ALU_CIL; end
              RO_INC: begin ac_ld_s = 1'b1; alu_op_s = ALU_INC; end
              RO_SZA: pc_inc_s = ac_zero;
              RO_SEZ: pc_inc_s = ~e_in;
              RO_HLT: hlt_s = 1'b1;
              default: clr_s = 1'b1;
            endcase
          end else begin
            // opcodes 8-F are NOPs
            clr_s = 1'b1;
          end
        end
        T3: begin
          case (op_s)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              mem_rd_s = 1'b1;
              dr_ld_s  = 1'b1;
            end
            OP_STA: begin
              mem_wr_s = 1'b1;
              wr_sel_s = WS_AC;
              clr_s    = 1'b1;
            end
            OP_BUN: begin
              pc_ld_s = 1'b1;
              clr_s   = 1'b1;
            end
            OP_BSA: begin
              // store return address, then step AR to the subroutine body
              mem_wr_s = 1'b1;
              wr_sel_s = WS_PC;
              ar_inc_s = 1'b1;
            end
            default: clr_s = 1'b1;
          endcase
        end
        T4: begin
          case (op_s)
            OP_AND: begin ac_ld_s = 1'b1; alu_op_s = ALU_AND; clr_s = 1'b1; end
            OP_ADD: begin ac_ld_s = 1'b1; e_ld_s = 1'b1; alu_op_s = ALU_ADD; clr_s = 1'b1; end
            OP_LDA: begin ac_ld_s = 1'b1; alu_op_s = ALU_PASS; clr_s = 1'b1; end
            OP_BSA: begin pc_ld_s = 1'b1; clr_s = 1'b1; end
            OP_ISZ: dr_inc_s = 1'b1;
            default: clr_s = 1'b1;
          endcase
        end
        T5: begin
          // only ISZ reaches T5; dr_zero already reflects the incremented DR
          clr_s = 1'b1;
          if (op_s == OP_ISZ) begin
            mem_wr_s = 1'b1;
            wr_sel_s = WS_DR;
            pc_inc_s = dr_zero;
          end else begin
            mem_wr_s = 1'b0;
          end
        end
        default: clr_s = 1'b1;
      endcase
    end else begin
      clr_s = 1'b0;
    end

    case (state_r)
      ST_HALT: begin
        sc_nxt_s = T0;
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_RUN: begin
        if (hlt_s) begin
          state_nxt_s = ST_HALT;
          sc_nxt_s    = T0;
        end else if (clr_s || (sc_r >= T5)) begin
          state_nxt_s = ST_RUN;
          sc_nxt_s    = T0;
        end else begin
          state_nxt_s = ST_RUN;
          sc_nxt_s    = sc_r + SC_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_HALT;
        sc_nxt_s    = T0;
      end
    endcase
  end

  assign sc     = sc_r;
  assign halted = (state_r == ST_HALT);

  // Strobes are masked by rst_n so a reset kills them within the same cycle
  assign ar_ld  = ar_ld_s  & rst_n;
  assign ar_sel = ar_sel_s & rst_n;
  assign ar_inc = ar_inc_s & rst_n;
  assign pc_ld  = pc_ld_s  & rst_n;
  assign pc_inc = pc_inc_s & rst_n;
  assign ir_ld  = ir_ld_s  & rst_n;
  assign dr_ld  = dr_ld_s  & rst_n;
  assign dr_inc = dr_inc_s & rst_n;
  assign mem_rd = mem_rd_s & rst_n;
  assign mem_wr = mem_wr_s & rst_n;
  assign wr_sel = wr_sel_s & {2{rst_n}};
  assign ac_ld  = ac_ld_s  & rst_n;
  assign e_ld   = e_ld_s   & rst_n;
  assign alu_op = alu_op_s & {4{rst_n}};

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus process pushes the
// expected output vector for every cycle it drives; a monitor pops and
// compares on each falling edge. A second instance with AUTO_START=0 is
// checked directly around reset and start.

module tb_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       start1  = 1'b0;
  logic [7:0] ir      = 8'h00;
  logic       ac_zero = 1'b0;
  logic       dr_zero = 1'b0;
  logic       e_in    = 1'b0;

  logic [2:0] sc, sc1;
  logic       halted, ar_ld, ar_sel, ar_inc, pc_ld, pc_inc, ir_ld, dr_ld, dr_inc, mem_rd, mem_wr, ac_ld, e_ld;
  logic       halted1, ar_ld1, ar_sel1, ar_inc1, pc_ld1, pc_inc1, ir_ld1, dr_ld1, dr_inc1, mem_rd1, mem_wr1, ac_ld1, e_ld1;
  logic [1:0] wr_sel, wr_sel1;
  logic [3:0] alu_op, alu_op1;

  control_sequencer #(.AUTO_START(1'b1), .SC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .ac_zero(ac_zero),
    .dr_zero(dr_zero), .e_in(e_in), .sc(sc), .halted(halted),
    .ar_ld(ar_ld), .ar_sel(ar_sel), .ar_inc(ar_inc), .pc_ld(pc_ld),
    .pc_inc(pc_inc), .ir_ld(ir_ld), .dr_ld(dr_ld), .dr_inc(dr_inc),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wr_sel(wr_sel), .ac_ld(ac_ld),
    .e_ld(e_ld), .alu_op(alu_op)
  );

  control_sequencer #(.AUTO_START(1'b0), .SC_W(3)) dut_halt (
    .clk(clk), .rst_n(rst_n), .start(start1), .ir(ir), .ac_zero(ac_zero),
    .dr_zero(dr_zero), .e_in(e_in), .sc(sc1), .halted(halted1),
    .ar_ld(ar_ld1), .ar_sel(ar_sel1), .ar_inc(ar_inc1), .pc_ld(pc_ld1),
    .pc_inc(pc_inc1), .ir_ld(ir_ld1), .dr_ld(dr_ld1), .dr_inc(dr_inc1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .wr_sel(wr_sel1), .ac_ld(ac_ld1),
    .e_ld(e_ld1), .alu_op(alu_op1)
  );

  // strobe masks: ar_ld ar_sel ar_inc pc_ld pc_inc ir_ld dr_ld dr_inc mem_rd mem_wr
  localparam logic [9:0] N      = 10'b0000000000;
  localparam logic [9:0] AR_LD  = 10'b1000000000;
  localparam logic [9:0] AR_SEL = 10'b0100000000;
  localparam logic [9:0] AR_INC = 10'b0010000000;
  localparam logic [9:0] PC_LD  = 10'b0001000000;
  localparam logic [9:0] PC_INC = 10'b0000100000;
  localparam logic [9:0] IR_LD  = 10'b0000010000;
  localparam logic [9:0] DR_LD  = 10'b0000001000;
  localparam logic [9:0] DR_INC = 10'b0000000100;
  localparam logic [9:0] MEM_RD = 10'b0000000010;
  localparam logic [9:0] MEM_WR = 10'b0000000001;

  logic [21:0] act0, act1;
  assign act0 = {halted, sc, ar_ld, ar_sel, ar_inc, pc_ld, pc_inc, ir_ld, dr_ld, dr_inc,
                 mem_rd, mem_wr, wr_sel, ac_ld, e_ld, alu_op};
  assign act1 = {halted1, sc1, ar_ld1, ar_sel1, ar_inc1, pc_ld1, pc_inc1, ir_ld1, dr_ld1, dr_inc1,
                 mem_rd1, mem_wr1, wr_sel1, ac_ld1, e_ld1, alu_op1};

  typedef struct {
    logic [21:0] vec;
    string       tag;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [21:0] mk(input logic h, input logic [2:0] s, input logic [9:0] st,
                                     input logic [1:0] ws, input logic ac, input logic e,
                                     input logic [3:0] op);
    return {h, s, st, ws, ac, e, op};
  endfunction

  task automatic chk(input logic [21:0] a, input logic [21:0] e, input string tag);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, a, e, $time);
    end
  endtask

  // monitor: compare the DUT outputs against the oldest expected entry
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(act0, e.vec, e.tag);
    end
  end

  task automatic cyc(input logic r, input logic stt, input logic [7:0] i, input logic az,
                     input logic dz, input logic ei, input logic [21:0] e, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = r; start = stt; ir = i; ac_zero = az; dr_zero = dz; e_in = ei;
    x.vec = e;
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic run(input logic [7:0] i, input logic az, input logic dz, input logic ei,
                     input logic [21:0] e, input string tag);
    cyc(1'b1, 1'b0, i, az, dz, ei, e, tag);
  endtask

  task automatic fetch(input logic [7:0] i, input logic az, input logic dz, input logic ei);
    run(i, az, dz, ei, mk(1'b0, 3'd0, AR_LD, 2'd0, 1'b0, 1'b0, 4'd0), "T0 fetch");
    run(i, az, dz, ei, mk(1'b0, 3'd1, MEM_RD | IR_LD | PC_INC, 2'd0, 1'b0, 1'b0, 4'd0), "T1 fetch");
  endtask

  // register-op table: ir, ac_zero, e_in, T2 strobes, ac_ld, e_ld, alu_op
  typedef struct {
    logic [7:0] i;
    logic       az;
    logic       ei;
    logic [9:0] st;
    logic       ac;
    logic       e;
    logic [3:0] op;
  } rop_t;

  rop_t rops[13];

  initial begin
    fork
      begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    rops[0]  = '{8'h70, 1'b0, 1'b0, N,      1'b1, 1'b0, 4'd3};
    rops[1]  = '{8'h71, 1'b0, 1'b0, N,      1'b1, 1'b0, 4'd4};
    rops[2]  = '{8'h72, 1'b0, 1'b0, N,      1'b0, 1'b1, 4'd8};
    rops[3]  = '{8'h73, 1'b0, 1'b0, N,      1'b1, 1'b1, 4'd5};
    rops[4]  = '{8'h74, 1'b0, 1'b0, N,      1'b1, 1'b1, 4'd6};
    rops[5]  = '{8'h75, 1'b0, 1'b0, N,      1'b1, 1'b0, 4'd7};
    rops[6]  = '{8'h76, 1'b1, 1'b0, PC_INC, 1'b0, 1'b0, 4'd0};
    rops[7]  = '{8'h76, 1'b0, 1'b0, N,      1'b0, 1'b0, 4'd0};
    rops[8]  = '{8'h77, 1'b0, 1'b0, PC_INC, 1'b0, 1'b0, 4'd0};
    rops[9]  = '{8'h77, 1'b0, 1'b1, N,      1'b0, 1'b0, 4'd0};
    rops[10] = '{8'h7A, 1'b1, 1'b0, N,      1'b0, 1'b0, 4'd0};
    rops[11] = '{8'h8C, 1'b1, 1'b1, N,      1'b0, 1'b0, 4'd0};
    rops[12] = '{8'hF0, 1'b1, 1'b1, N,      1'b0, 1'b0, 4'd0};

    // reset state
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd0, N, 2'd0, 1'b0, 1'b0, 4'd0), "reset");
    #1 chk(act1, mk(1'b1, 3'd0, N, 2'd0, 1'b0, 1'b0, 4'd0), "reset halted inst");

    // LDA 3
    fetch(8'h23, 1'b0, 1'b0, 1'b0);
    #1 chk(act1, mk(1'b1, 3'd0, N, 2'd0, 1'b0, 1'b0, 4'd0), "halted inst after release");
    run(8'h23, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, AR_LD | AR_SEL, 2'd0, 1'b0, 1'b0, 4'd0), "LDA T2");
    run(8'h23, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd3, MEM_RD | DR_LD, 2'd0, 1'b0, 1'b0, 4'd0), "LDA T3");
    run(8'h23, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd4, N, 2'd0, 1'b1, 1'b0, 4'd2), "LDA T4");

    // STA 5
    fetch(8'h35, 1'b0, 1'b0, 1'b0);
    run(8'h35, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, AR_LD | AR_SEL, 2'd0, 1'b0, 1'b0, 4'd0), "STA T2");
    run(8'h35, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd3, MEM_WR, 2'd0, 1'b0, 1'b0, 4'd0), "STA T3");

    // AND 7 and ADD 2
    fetch(8'h07, 1'b0, 1'b0, 1'b0);
    run(8'h07, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, AR_LD | AR_SEL, 2'd0, 1'b0, 1'b0, 4'd0), "AND T2");
    run(8'h07, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd3, MEM_RD | DR_LD, 2'd0, 1'b0, 1'b0, 4'd0), "AND T3");
    run(8'h07, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd4, N, 2'd0, 1'b1, 1'b0, 4'd0), "AND T4");
    fetch(8'h12, 1'b0, 1'b0, 1'b0);
    run(8'h12, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, AR_LD | AR_SEL, 2'd0, 1'b0, 1'b0, 4'd0), "ADD T2");
    run(8'h12, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd3, MEM_RD | DR_LD, 2'd0, 1'b0, 1'b0, 4'd0), "ADD T3");
    run(8'h12, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd4, N, 2'd0, 1'b1, 1'b1, 4'd1), "ADD T4");

    // ISZ A, with and without the skip
    for (int k = 0; k < 2; k++) begin
      logic dz;
      dz = (k == 0);
      fetch(8'h6A, 1'b0, dz, 1'b0);
      run(8'h6A, 1'b0, dz, 1'b0, mk(1'b0, 3'd2, AR_LD | AR_SEL, 2'd0, 1'b0, 1'b0, 4'd0), "ISZ T2");
      run(8'h6A, 1'b0, dz, 1'b0, mk(1'b0, 3'd3, MEM_RD | DR_LD, 2'd0, 1'b0, 1'b0, 4'd0), "ISZ T3");
      run(8'h6A, 1'b0, dz, 1'b0, mk(1'b0, 3'd4, DR_INC, 2'd0, 1'b0, 1'b0, 4'd0), "ISZ T4");
      run(8'h6A, 1'b0, dz, 1'b0, mk(1'b0, 3'd5, dz ? (MEM_WR | PC_INC) : MEM_WR, 2'd2, 1'b0, 1'b0, 4'd0),
          dz ? "ISZ T5 skip" : "ISZ T5 noskip");
    end

    // BSA F
    fetch(8'h5F, 1'b0, 1'b0, 1'b0);
    run(8'h5F, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, AR_LD | AR_SEL, 2'd0, 1'b0, 1'b0, 4'd0), "BSA T2");
    run(8'h5F, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd3, MEM_WR | AR_INC, 2'd1, 1'b0, 1'b0, 4'd0), "BSA T3");
    run(8'h5F, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd4, PC_LD, 2'd0, 1'b0, 1'b0, 4'd0), "BSA T4");

    // BUN 3
    fetch(8'h43, 1'b0, 1'b0, 1'b0);
    run(8'h43, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, AR_LD | AR_SEL, 2'd0, 1'b0, 1'b0, 4'd0), "BUN T2");
    run(8'h43, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd3, PC_LD, 2'd0, 1'b0, 1'b0, 4'd0), "BUN T3");

    // register ops and NOPs, each completes in T2
    foreach (rops[k]) begin
      fetch(rops[k].i, rops[k].az, 1'b0, rops[k].ei);
      run(rops[k].i, rops[k].az, 1'b0, rops[k].ei,
          mk(1'b0, 3'd2, rops[k].st, 2'd0, rops[k].ac, rops[k].e, rops[k].op), "regop/nop T2");
    end

    // start held high while running has no effect
    cyc(1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd0, AR_LD, 2'd0, 1'b0, 1'b0, 4'd0), "start in run T0");
    cyc(1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd1, MEM_RD | IR_LD | PC_INC, 2'd0, 1'b0, 1'b0, 4'd0), "start in run T1");
    cyc(1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, N, 2'd0, 1'b0, 1'b0, 4'd0), "start in run T2");

    // HLT, idle in HALT, then start
    fetch(8'h7F, 1'b0, 1'b0, 1'b0);
    run(8'h7F, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, N, 2'd0, 1'b0, 1'b0, 4'd0), "HLT T2");
    run(8'h7F, 1'b0, 1'b0, 1'b0, mk(1'b1, 3'd0, N, 2'd0, 1'b0, 1'b0, 4'd0), "halted idle 1");
    start1 = 1'b1;
    run(8'h7F, 1'b0, 1'b0, 1'b0, mk(1'b1, 3'd0, N, 2'd0, 1'b0, 1'b0, 4'd0), "halted idle 2");
    start1 = 1'b0;
    #1 chk(act1, mk(1'b0, 3'd0, AR_LD, 2'd0, 1'b0, 1'b0, 4'd0), "halted inst started T0");
    cyc(1'b1, 1'b1, 8'h23, 1'b0, 1'b0, 1'b0, mk(1'b1, 3'd0, N, 2'd0, 1'b0, 1'b0, 4'd0), "start cycle");
    run(8'h23, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd0, AR_LD, 2'd0, 1'b0, 1'b0, 4'd0), "restart T0");
    run(8'h23, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd1, MEM_RD | IR_LD | PC_INC, 2'd0, 1'b0, 1'b0, 4'd0), "restart T1");
    run(8'h23, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, AR_LD | AR_SEL, 2'd0, 1'b0, 1'b0, 4'd0), "restart T2");
    run(8'h23, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd3, MEM_RD | DR_LD, 2'd0, 1'b0, 1'b0, 4'd0), "restart T3");
    run(8'h23, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd4, N, 2'd0, 1'b1, 1'b0, 4'd2), "restart T4");

    // reset asserted during T4 of ADD
    fetch(8'h12, 1'b0, 1'b0, 1'b0);
    run(8'h12, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, AR_LD | AR_SEL, 2'd0, 1'b0, 1'b0, 4'd0), "ADD2 T2");
    run(8'h12, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd3, MEM_RD | DR_LD, 2'd0, 1'b0, 1'b0, 4'd0), "ADD2 T3");
    run(8'h12, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd4, N, 2'd0, 1'b1, 1'b1, 4'd1), "ADD2 T4");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk(act0, mk(1'b0, 3'd0, N, 2'd0, 1'b0, 1'b0, 4'd0), "async reset mid T4");
    chk(act1, mk(1'b1, 3'd0, N, 2'd0, 1'b0, 1'b0, 4'd0), "async reset halted inst");
    cyc(1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd0, N, 2'd0, 1'b0, 1'b0, 4'd0), "held in reset");
    fetch(8'h23, 1'b0, 1'b0, 1'b0);
    #1 chk(act1, mk(1'b1, 3'd0, N, 2'd0, 1'b0, 1'b0, 4'd0), "halted inst after 2nd release");

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
